// File: rtl/loom_dpi_pkg.sv
// loom_dpi_pkg: shared types and widths for the DPI call-slot bridge blocks.
package loom_dpi_pkg;
  localparam int LOOM_DPI_WORD_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} dpi_arb_state_e;
  function automatic int loom_dpi_ret_w(input int max_args);
    return 64 + max_args * LOOM_DPI_WORD_W;
  endfunction
endpackage

// File: rtl/loom_rr_arbiter.sv
// loom_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module loom_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/loom_dpi_call_arbiter.sv
// loom_dpi_call_arbiter: shares one DPI function slot among N_CALLERS call sites,
// one call in flight at a time, round-robin between callers.
module loom_dpi_call_arbiter
  import loom_dpi_pkg::*;
#(
  parameter int N_CALLERS      = 4,
  parameter int MAX_ARGS       = 8,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [N_CALLERS-1:0]                          req_valid_i,
  input  logic [N_CALLERS*MAX_ARGS*LOOM_DPI_WORD_W-1:0] req_args_i,
  output logic [N_CALLERS-1:0]                          grant_o,
  output logic [N_CALLERS-1:0]                          ret_valid_o,
  input  logic [N_CALLERS-1:0]                          ret_ready_i,
  output logic [loom_dpi_ret_w(MAX_ARGS)-1:0]           ret_data_o,
  output logic [N_CALLERS-1:0]                          stall_o,
  output logic                                          call_valid_o,
  input  logic                                          call_ready_i,
  output logic [MAX_ARGS*LOOM_DPI_WORD_W-1:0]           call_args_o,
  input  logic                                          ret_valid_i,
  output logic                                          ret_ready_o,
  input  logic [loom_dpi_ret_w(MAX_ARGS)-1:0]           ret_data_i,
  output logic                                          timeout_o,
  output logic [31:0]                                   call_count_o
);
  localparam int AW = MAX_ARGS * LOOM_DPI_WORD_W;
  localparam int IW = N_CALLERS > 1 ? $clog2(N_CALLERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  dpi_arb_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, grant_q, pick_idx, next_ptr;
  logic [N_CALLERS-1:0] pick_gnt, grant_oh;
  logic pick_any, req_g, rdy_g;
  logic [AW-1:0] sel_args;
  logic [CW-1:0] wait_cnt_q;
  loom_rr_arbiter #(.N(N_CALLERS)) u_rr (
    .req(req_valid_i),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    sel_args = '0;
    for (int i = 0; i < N_CALLERS; i++)
      sel_args = sel_args | (pick_gnt[i] ? req_args_i[i*AW +: AW] : '0);
  end
  assign grant_oh     = N_CALLERS'(1) << grant_q;
  assign req_g        = req_valid_i[grant_q];
  assign rdy_g        = ret_ready_i[grant_q];
  assign next_ptr     = (grant_q == IW'(N_CALLERS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_o      = (state_q == IDLE) ? '0 : grant_oh;
  assign ret_valid_o  = (state_q == DELIVER) ? grant_oh : '0;
  assign stall_o      = req_valid_i & ~ret_valid_o;
  assign call_valid_o = state_q == ISSUE;
  assign ret_ready_o  = (state_q == WAIT) && ret_valid_i;
  // A call accepted by the slot is always seen through, even if the caller leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_any ? ISSUE : IDLE;
      ISSUE:   state_d = call_ready_i ? WAIT : (req_g ? ISSUE : IDLE);
      WAIT:    state_d = ret_valid_i ? DELIVER : WAIT;
      DELIVER: state_d = (rdy_g || !req_g) ? IDLE : DELIVER;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      grant_q      <= '0;
      call_args_o  <= '0;
      ret_data_o   <= '0;
      wait_cnt_q   <= '0;
      timeout_o    <= 1'b0;
      call_count_o <= '0;
    end else begin
      if (state_q == IDLE && pick_any) begin
        grant_q     <= pick_idx;
        call_args_o <= sel_args;
      end
      if (state_q == ISSUE && call_ready_i) wait_cnt_q <= '0;
      if (state_q == WAIT) begin
        if (wait_cnt_q != CW'(TIMEOUT_CYCLES)) wait_cnt_q <= wait_cnt_q + 1'b1;
        if (wait_cnt_q >= CW'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
        if (ret_valid_i) ret_data_o <= ret_data_i;
      end
      if (state_q == DELIVER && (rdy_g || !req_g)) begin
        ptr_q <= next_ptr;
        if (rdy_g) call_count_o <= call_count_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_loom_dpi_call_arbiter.sv
// tb_loom_dpi_call_arbiter: directed and random calls checked against a request-set/pointer model.
module tb_loom_dpi_call_arbiter;
  localparam int T = 16;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [3:0] req_valid_i, grant_o, ret_valid_o, ret_ready_i, stall_o;
  logic [1023:0] req_args_i;
  logic [255:0] args [4];
  logic [319:0] ret_data_o, ret_data_i;
  logic call_valid_o, call_ready_i, ret_valid_i, ret_ready_o, timeout_o;
  logic [255:0] call_args_o;
  logic [31:0] call_count_o;
  int total = 0, bad = 0;
  int m_ptr = 0, m_count = 0;
  bit m_timeout = 0;
  always #5 clk_i = ~clk_i;
  assign req_args_i = {args[3], args[2], args[1], args[0]};
  loom_dpi_call_arbiter #(.N_CALLERS(4), .MAX_ARGS(8), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_args_i(req_args_i),
    .grant_o(grant_o), .ret_valid_o(ret_valid_o), .ret_ready_i(ret_ready_i),
    .ret_data_o(ret_data_o), .stall_o(stall_o), .call_valid_o(call_valid_o),
    .call_ready_i(call_ready_i), .call_args_o(call_args_o), .ret_valid_i(ret_valid_i),
    .ret_ready_o(ret_ready_o), .ret_data_i(ret_data_i), .timeout_o(timeout_o),
    .call_count_o(call_count_o)
  );
  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask
  function automatic logic [255:0] rnd_args();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [319:0] rnd_ret();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_retv"}, ret_valid_o, 0);
    chk({tag, "_callv"}, call_valid_o, 0);
    chk({tag, "_retr"}, ret_ready_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
    chk({tag, "_cnt"}, call_count_o, 0);
    chk({tag, "_args"}, call_args_o, 0);
    chk({tag, "_data"}, ret_data_o, 0);
  endtask
  task automatic model_reset;
    m_ptr = 0;
    m_count = 0;
    m_timeout = 0;
  endtask
  // Entered in IDLE with at least one request up; leaves in IDLE after the call ends.
  task automatic run_call(input logic [319:0] rdv, input int lat, input int dly, input bit wd);
    int g;
    logic [3:0] oh;
    logic [255:0] ea;
    g = pick(req_valid_i, m_ptr);
    oh = 4'(1 << g);
    ea = args[g];
    tick;
    for (int k = 0; k < 4; k++) args[k] = rnd_args();
    #1;
    chk("issue_valid", call_valid_o, 1);
    chk("issue_grant", grant_o, oh);
    chk("issue_args", call_args_o, ea);
    call_ready_i = 1'b1;
    tick;
    call_ready_i = 1'b0;
    #1;
    chk("wait_callv", call_valid_o, 0);
    chk("wait_stall", stall_o, req_valid_i);
    for (int i = 0; i < lat; i++) begin
      tick;
      chk("wait_tmo", timeout_o, m_timeout || (i + 1 >= T));
      chk("wait_retr", ret_ready_o, 0);
    end
    ret_valid_i = 1'b1;
    ret_data_i = rdv;
    #1;
    chk("wait_retr_hs", ret_ready_o, 1);
    tick;
    ret_valid_i = 1'b0;
    ret_data_i = rnd_ret();
    m_timeout = m_timeout || (lat + 1 >= T);
    #1;
    chk("dlv_retv", ret_valid_o, oh);
    chk("dlv_data", ret_data_o, rdv);
    chk("dlv_stall", stall_o, req_valid_i & ~oh);
    chk("dlv_tmo", timeout_o, m_timeout);
    chk("dlv_retr", ret_ready_o, 0);
    for (int i = 0; i < dly; i++) begin
      ret_ready_i = 4'($urandom) & ~oh;
      tick;
      chk("hold_retv", ret_valid_o, oh);
      chk("hold_data", ret_data_o, rdv);
      chk("hold_callv", call_valid_o, 0);
    end
    ret_ready_i = wd ? 4'($urandom) & ~oh : oh | 4'($urandom);
    if (wd) req_valid_i[g] = 1'b0;
    tick;
    ret_ready_i = '0;
    req_valid_i[g] = 1'b0;
    m_ptr = (g + 1) % 4;
    if (!wd) m_count++;
    #1;
    chk("end_cnt", call_count_o, m_count);
    chk("end_grant", grant_o, 0);
    chk("end_retv", ret_valid_o, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    rst_ni = 1'b0;
    req_valid_i = '0;
    ret_ready_i = '0;
    call_ready_i = 1'b0;
    ret_valid_i = 1'b0;
    ret_data_i = '0;
    for (int k = 0; k < 4; k++) args[k] = rnd_args();
    tick;
    tick;
    chk_zero("rst");
    rst_ni = 1'b1;
    tick;
    chk_zero("idle");
    chk("idle_stall", stall_o, 0);
    // T1: lone caller 2
    args[2][31:0] = 32'h1234;
    req_valid_i = 4'b0100;
    run_call(320'hCAFE, 5, 0, 0);
    chk("t1_cnt", call_count_o, 1);
    // T2: callers 0,1,3 from a fresh pointer, requests held across calls
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    model_reset();
    req_valid_i = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      run_call(rnd_ret(), 0, 0, 0);
      req_valid_i = 4'b1011;
    end
    req_valid_i = '0;
    chk("t2_ptr_model", 32'(m_ptr), 1);
    // T3: caller 1 abandons its ISSUE before the slot is ready
    req_valid_i = 4'b0010;
    tick;
    #1;
    chk("t3_issue", call_valid_o, 1);
    chk("t3_grant", grant_o, 4'b0010);
    req_valid_i = '0;
    tick;
    #1;
    chk("t3_idle_callv", call_valid_o, 0);
    chk("t3_idle_grant", grant_o, 0);
    chk("t3_cnt", call_count_o, m_count);
    req_valid_i = 4'b0011;
    run_call(rnd_ret(), 2, 0, 0);
    // T5: caller 0 stalls its result for 10 cycles
    run_call(rnd_ret(), 1, 10, 0);
    // caller 3 leaves during DELIVER: result dropped, pointer still moves
    req_valid_i = 4'b1000;
    run_call(rnd_ret(), 3, 2, 1);
    chk("wd_ptr", 32'(pick(4'b1111, m_ptr)), 0);
    // T4: slot withholds its return past the timeout
    req_valid_i = 4'b0100;
    run_call(rnd_ret(), 20, 0, 0);
    tick;
    chk("t4_sticky", timeout_o, 1);
    // T6: reset while a call sits in WAIT
    req_valid_i = 4'b0010;
    tick;
    call_ready_i = 1'b1;
    tick;
    call_ready_i = 1'b0;
    tick;
    rst_ni = 1'b0;
    #1;
    chk_zero("t6_async");
    tick;
    chk_zero("t6_held");
    rst_ni = 1'b1;
    model_reset();
    run_call(rnd_ret(), 4, 1, 0);
    chk("t6_cnt", call_count_o, 1);
    // random traffic
    for (int n = 0; n < 30; n++) begin
      req_valid_i = req_valid_i | 4'($urandom_range(1, 15));
      run_call(rnd_ret(), $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
    end
    req_valid_i = '0;
    tick;
    chk("final_cnt", call_count_o, m_count);
    chk("final_tmo", timeout_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
